multicycle_controller: RTL

- Multi-cycle control FSM that drives the 16-bit processor datapath.
- Samples the datapath's instruction bus plus the ALU zero flag and a memory-ready strobe.
- Sequences each instruction through fetch, decode, execute, memory and write-back.
- Produces every datapath enable and select: register write, PC load, branch/jump PC select, immediate select, memory read/write. It also owns the register-window register and a retired-instruction counter.

---
 rtl/multicycle_controller.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_controller.sv
// ============================================================================
// Module   : multicycle_controller
// Purpose  : Multi-cycle FETCH/DECODE/EXEC/MEM/WB control FSM for a 16-bit
//            datapath; WINSET (opcode 6) is enabled by macro WINDOW_OPS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_controller #(
    parameter int INSTR_W = 16,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [INSTR_W-1:0] instruction,
    input  logic               Zero,
    input  logic               MemReady,
    output logic               InstructionLoad,
    output logic               SelectImm,
    output logic               RegisterWriteDataEnable,
    output logic               MemoryReadDataEnable,
    output logic               MemoryWriteDataEnable,
    output logic               LoadPcEnable,
    output logic               SelectBranchPc,
    output logic               SelectJumpPc,
    output logic [1:0]         Window,
    output logic               Halted,
    output logic               Illegal,
    output logic [CNT_W-1:0]   RetiredCount
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [3:0] c_OP_ALU    = 4'h0;
    localparam logic [3:0] c_OP_ADDI   = 4'h1;
    localparam logic [3:0] c_OP_LOAD   = 4'h2;
    localparam logic [3:0] c_OP_STORE  = 4'h3;
    localparam logic [3:0] c_OP_JUMP   = 4'h4;
    localparam logic [3:0] c_OP_BZ     = 4'h5;
`ifdef WINDOW_OPS_EN
    localparam logic [3:0] c_OP_WINSET = 4'h6;
`endif
    localparam logic [3:0] c_OP_HALT   = 4'hF;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [3:0]       r_opcode;
    logic             r_illegal;
    logic [CNT_W-1:0] r_count;
    logic             w_set_illegal;
    logic             w_win_load;
    logic             w_imm_op;
    logic             w_unused;

    // Only the opcode and (optionally) the window field are decoded here.
    assign w_unused = ^instruction[INSTR_W-5:0];

    assign w_imm_op = (r_opcode == c_OP_ADDI) || (r_opcode == c_OP_LOAD) ||
                      (r_opcode == c_OP_STORE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_FETCH;
            r_opcode  <= 4'h0;
            r_illegal <= 1'b0;
            r_count   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (InstructionLoad) begin
                r_opcode <= instruction[INSTR_W-1 -: 4];
            end
            if (w_set_illegal) begin
                r_illegal <= 1'b1;
            end
            if (LoadPcEnable) begin
                r_count <= r_count + CNT_W'(1);
            end
        end
    end

    // Outputs are gated by rst so no enable is visible while reset is held.
    always_comb begin
        w_state_nxt             = r_state;
        w_set_illegal           = 1'b0;
        w_win_load              = 1'b0;
        InstructionLoad         = 1'b0;
        SelectImm               = 1'b0;
        RegisterWriteDataEnable = 1'b0;
        MemoryReadDataEnable    = 1'b0;
        MemoryWriteDataEnable   = 1'b0;
        LoadPcEnable            = 1'b0;
        SelectBranchPc          = 1'b0;
        SelectJumpPc            = 1'b0;
        if (rst) begin
            case (r_state)
                S_FETCH: begin
                    InstructionLoad = 1'b1;
                    w_state_nxt     = S_DECODE;
                end
                S_DECODE: begin
                    case (r_opcode)
                        c_OP_ALU, c_OP_ADDI, c_OP_LOAD, c_OP_STORE, c_OP_BZ: begin
                            w_state_nxt = S_EXEC;
                        end
                        c_OP_JUMP: begin
                            LoadPcEnable = 1'b1;
                            SelectJumpPc = 1'b1;
                            w_state_nxt  = S_FETCH;
                        end
`ifdef WINDOW_OPS_EN
                        c_OP_WINSET: begin
                            w_win_load   = 1'b1;
                            LoadPcEnable = 1'b1;
                            w_state_nxt  = S_FETCH;
                        end
`endif
                        c_OP_HALT: begin
                            w_state_nxt = S_HALT;
                        end
                        default: begin
                            w_set_illegal = 1'b1;
                            LoadPcEnable  = 1'b1;
                            w_state_nxt   = S_FETCH;
                        end
                    endcase
                end
                S_EXEC: begin
                    SelectImm = w_imm_op;
                    case (r_opcode)
                        c_OP_ALU, c_OP_ADDI: w_state_nxt = S_WB;
                        c_OP_LOAD, c_OP_STORE: w_state_nxt = S_MEM;
                        c_OP_BZ: begin
                            LoadPcEnable   = 1'b1;
                            SelectBranchPc = Zero;
                            w_state_nxt    = S_FETCH;
                        end
                        default: w_state_nxt = S_FETCH;
                    endcase
                end
                S_MEM: begin
                    // Only LOAD and STORE reach MEM, so "not LOAD" means STORE.
                    MemoryReadDataEnable  = (r_opcode == c_OP_LOAD);
                    MemoryWriteDataEnable = (r_opcode != c_OP_LOAD);
                    if (MemReady) begin
                        if (r_opcode == c_OP_LOAD) begin
                            w_state_nxt = S_WB;
                        end else begin
                            LoadPcEnable = 1'b1;
                            w_state_nxt  = S_FETCH;
                        end
                    end
                end
                S_WB: begin
                    RegisterWriteDataEnable = 1'b1;
                    SelectImm               = w_imm_op;
                    LoadPcEnable            = 1'b1;
                    w_state_nxt             = S_FETCH;
                end
                S_HALT: begin
                    w_state_nxt = S_HALT;
                end
                default: begin
                    w_state_nxt = S_FETCH;
                end
            endcase
        end
    end

`ifdef WINDOW_OPS_EN
    logic [1:0] r_window;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_window <= 2'b00;
        end else if (w_win_load) begin
            r_window <= instruction[1:0];
        end
    end

    assign Window = r_window;
`else
    logic w_unused_win;
    assign w_unused_win = w_win_load;
    assign Window       = 2'b00;
`endif

    assign Halted       = (r_state == S_HALT);
    assign Illegal      = r_illegal;
    assign RetiredCount = r_count;

endmodule

`default_nettype wire
